// File: rtl/door_input_cond.sv
// Door input conditioning stage that feeds the door-control FSM.
// It synchronizes and debounces four field inputs (presence, e-stop, open
// limit, closed limit). It stretches presence with a hold-open window and
// latches a sticky fault when both limit switches read active together.

// One input channel: 2-flop synchronizer followed by a run-length debouncer.
module door_input_chan #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic raw_i,
    output logic db_o,
    output logic db_d_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1_q, s2_q, db_q, db_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Count consecutive disagreements; any agreement restarts the run
    always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        if (s2_q == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            db_d  = s2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Synchronizer, counter and debounced value all freeze with ena low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            cnt_q <= '0;
            db_q  <= 1'b0;
        end else if (ena) begin
            s1_q  <= raw_i;
            s2_q  <= s1_q;
            cnt_q <= cnt_d;
            db_q  <= db_d;
        end
    end

    assign db_o   = db_q;
    assign db_d_o = db_d;
endmodule

module door_input_cond #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic raw_sen,
    input  logic raw_se,
    input  logic raw_la,
    input  logic raw_lc,
    input  logic fault_clr,
    output logic sen,
    output logic se,
    output logic la,
    output logic lc,
    output logic sen_rise,
    output logic fault
);
    localparam int NUM_CH = 4;
    localparam int CH_SEN = 0;
    localparam int CH_SE  = 1;
    localparam int CH_LA  = 2;
    localparam int CH_LC  = 3;
    localparam int HW     = $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LD = HW'(HOLD_CYCLES);

    logic [NUM_CH-1:0] raw, db, db_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic              sen_q, fault_q, fault_d;

    assign raw = {raw_lc, raw_la, raw_se, raw_sen};

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        door_input_chan #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .ena    (ena),
            .raw_i  (raw[g]),
            .db_o   (db[g]),
            .db_d_o (db_d[g])
        );
    end

    // Hold window: load on the edge presence falls so there is no gap, and
    // cancel immediately if presence returns
    always_comb begin
        hold_d = hold_q;
        if (db_d[CH_SEN])           hold_d = '0;
        else if (db[CH_SEN])        hold_d = HOLD_LD;
        else if (hold_q != '0)      hold_d = hold_q - HW'(1);
    end

    // Fault uses post-update limits so it lands in the same cycle as the
    // conflicting limit; a concurrent set beats the clear
    always_comb begin
        fault_d = (db_d[CH_LA] & db_d[CH_LC]) | (fault_q & ~fault_clr);
    end

    // Hold, edge-detect history and fault all freeze with ena low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q  <= '0;
            sen_q   <= 1'b0;
            fault_q <= 1'b0;
        end else if (ena) begin
            hold_q  <= hold_d;
            sen_q   <= sen;
            fault_q <= fault_d;
        end
    end

    assign sen      = db[CH_SEN] | (hold_q != '0);
    assign sen_rise = sen & ~sen_q;
    assign se       = db[CH_SE];
    assign la       = db[CH_LA] & ~fault_q;
    assign lc       = db[CH_LC] & ~fault_q;
    assign fault    = fault_q;
endmodule
